// File: rtl/sram_dp_par_wrap.sv
// Dual-port parity-protected SRAM wrapper: even parity per word, valid tracking,
// write-write collision detection and error status/capture logic.
module sram_dp_par_wrap #(
    parameter int unsigned DW    = 36,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned CW    = 8
) (
    input  logic          CLKA,
    input  logic          reset_n,
    input  logic          scan_mode,
    input  logic          MEA,
    input  logic          WEA,
    input  logic [AW-1:0] ADRA,
    input  logic [DW-1:0] DA,
    output logic [DW-1:0] QA,
    input  logic          MEB,
    input  logic          WEB,
    input  logic [AW-1:0] ADRB,
    input  logic [DW-1:0] DB,
    output logic [DW-1:0] QB,
    input  logic          inj_par_a,
    input  logic          err_clr,
    output logic          err_a,
    output logic          err_b,
    output logic          coll,
    output logic          err_sticky,
    output logic [CW-1:0] err_cnt,
    output logic [AW-1:0] err_addr,
    output logic          err_port
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DW:0]      mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DW-1:0]    qa_q, qb_q;
    logic             err_a_q, err_b_q, coll_q, sticky_q, port_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    addr_q;

    logic          act, in_a, in_b, rd_a, rd_b, wr_a, wr_b, coll_d;
    logic          err_a_d, err_b_d;
    logic [IW-1:0] ia, ib;
    logic [DW:0]   word_a, word_b;
    logic [1:0]    n_err;
    logic [CW:0]   cnt_sum;
    logic [CW-1:0] cnt_d;

    // Access qualification; reads of out-of-range addresses still return zero
    assign act    = reset_n & ~scan_mode;
    assign in_a   = {1'b0, ADRA} < (AW+1)'(DEPTH);
    assign in_b   = {1'b0, ADRB} < (AW+1)'(DEPTH);
    assign ia     = IW'(ADRA);
    assign ib     = IW'(ADRB);
    assign rd_a   = act & MEA & ~WEA;
    assign rd_b   = act & MEB & ~WEB;
    assign wr_a   = act & MEA & WEA & in_a;
    assign wr_b   = act & MEB & WEB & in_b;
    assign coll_d = wr_a & wr_b & (ADRA == ADRB);

    // Stored word is {parity, data}; any odd total parity is a corrupted word
    assign word_a  = mem_q[ia];
    assign word_b  = mem_q[ib];
    assign err_a_d = rd_a & in_a & valid_q[ia] & (^word_a);
    assign err_b_d = rd_b & in_b & valid_q[ib] & (^word_b);

    assign n_err   = {1'b0, err_a_d} + {1'b0, err_b_d};
    assign cnt_sum = {1'b0, cnt_q} + (CW+1)'(n_err);
    assign cnt_d   = cnt_sum[CW] ? CNT_MAX : cnt_sum[CW-1:0];

    // Data array is deliberately not reset; port A wins a same-address write
    always_ff @(posedge CLKA) begin
        if (wr_a) begin
            mem_q[ia] <= {(^DA) ^ inj_par_a, DA};
        end
        if (wr_b && !coll_d) begin
            mem_q[ib] <= {^DB, DB};
        end
    end

    always_ff @(posedge CLKA or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            qa_q     <= '0;
            qb_q     <= '0;
            err_a_q  <= 1'b0;
            err_b_q  <= 1'b0;
            coll_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            port_q   <= 1'b0;
        end else begin
            if (wr_a) valid_q[ia] <= 1'b1;
            if (wr_b) valid_q[ib] <= 1'b1;
            if (rd_a) qa_q <= in_a ? word_a[DW-1:0] : '0;
            if (rd_b) qb_q <= in_b ? word_b[DW-1:0] : '0;
            err_a_q <= err_a_d;
            err_b_q <= err_b_d;
            coll_q  <= coll_d;
            // Clear beats a simultaneous error; port A recorded on a tie
            if (err_clr) begin
                sticky_q <= 1'b0;
                cnt_q    <= '0;
                addr_q   <= '0;
                port_q   <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                if (!sticky_q && (err_a_d || err_b_d)) begin
                    sticky_q <= 1'b1;
                    addr_q   <= err_a_d ? ADRA : ADRB;
                    port_q   <= ~err_a_d;
                end
            end
        end
    end

    assign QA         = scan_mode ? '0 : qa_q;
    assign QB         = scan_mode ? '0 : qb_q;
    assign err_a      = err_a_q & ~scan_mode;
    assign err_b      = err_b_q & ~scan_mode;
    assign coll       = coll_q & ~scan_mode;
    assign err_sticky = sticky_q;
    assign err_cnt    = cnt_q;
    assign err_addr   = addr_q;
    assign err_port   = port_q;

endmodule

// File: tb/tb_sram_dp_par_wrap.sv
// Bench for sram_dp_par_wrap: directed scenarios plus random traffic checked
// against a word-level memory model that tracks corruption per address.
module tb_sram_dp_par_wrap;

    localparam int unsigned DW    = 36;
    localparam int unsigned DEPTH = 48;
    localparam int unsigned AW    = 6;
    localparam int unsigned CW    = 8;
    localparam int          CMAX  = 255;

    logic          CLKA = 1'b0;
    logic          reset_n, scan_mode, MEA, WEA, MEB, WEB, inj_par_a, err_clr;
    logic [AW-1:0] ADRA, ADRB;
    logic [DW-1:0] DA, DB, QA, QB;
    logic          err_a, err_b, coll, err_sticky, err_port;
    logic [CW-1:0] err_cnt;
    logic [AW-1:0] err_addr;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: contents, corruption flag and valid flag per word
    logic [DW-1:0] m_data [DEPTH];
    bit            m_bad  [DEPTH];
    bit            m_valid[DEPTH];
    logic [DW-1:0] m_qa, m_qb;
    bit            m_ea, m_eb, m_coll, m_sticky, m_port;
    int            m_cnt, m_addr;

    sram_dp_par_wrap #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .CLKA(CLKA), .reset_n(reset_n), .scan_mode(scan_mode),
        .MEA(MEA), .WEA(WEA), .ADRA(ADRA), .DA(DA), .QA(QA),
        .MEB(MEB), .WEB(WEB), .ADRB(ADRB), .DB(DB), .QB(QB),
        .inj_par_a(inj_par_a), .err_clr(err_clr),
        .err_a(err_a), .err_b(err_b), .coll(coll),
        .err_sticky(err_sticky), .err_cnt(err_cnt),
        .err_addr(err_addr), .err_port(err_port)
    );

    always #5 CLKA = ~CLKA;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("QA", 64'(QA), scan_mode ? 64'd0 : 64'(m_qa));
        chk("QB", 64'(QB), scan_mode ? 64'd0 : 64'(m_qb));
        chk("err_a", 64'(err_a), scan_mode ? 64'd0 : 64'(m_ea));
        chk("err_b", 64'(err_b), scan_mode ? 64'd0 : 64'(m_eb));
        chk("coll", 64'(coll), scan_mode ? 64'd0 : 64'(m_coll));
        chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
        chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
        chk("err_addr", 64'(err_addr), 64'(m_addr));
        chk("err_port", 64'(err_port), 64'(m_port));
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_valid[i] = 1'b0;
        m_qa = '0; m_qb = '0;
        m_ea = 0; m_eb = 0; m_coll = 0;
        m_sticky = 0; m_port = 0; m_cnt = 0; m_addr = 0;
    endtask

    // Effect of the coming clock edge, computed from the inputs now applied
    task automatic model_step();
        bit ina, inb, wa, wb, rda, rdb;
        if (!reset_n) begin
            model_reset();
            return;
        end
        ina = int'(ADRA) < int'(DEPTH);
        inb = int'(ADRB) < int'(DEPTH);
        rda = MEA && !scan_mode && !WEA;
        rdb = MEB && !scan_mode && !WEB;
        m_ea = 0;
        m_eb = 0;
        if (rda) begin
            m_qa = ina ? m_data[ADRA] : '0;
            m_ea = ina && m_valid[ADRA] && m_bad[ADRA];
        end
        if (rdb) begin
            m_qb = inb ? m_data[ADRB] : '0;
            m_eb = inb && m_valid[ADRB] && m_bad[ADRB];
        end
        wa = MEA && WEA && !scan_mode && ina;
        wb = MEB && WEB && !scan_mode && inb;
        m_coll = wa && wb && (ADRA == ADRB);
        if (wb && !m_coll) begin
            m_data[ADRB] = DB; m_bad[ADRB] = 0; m_valid[ADRB] = 1;
        end
        if (wa) begin
            m_data[ADRA] = DA; m_bad[ADRA] = inj_par_a; m_valid[ADRA] = 1;
        end
        if (err_clr) begin
            m_sticky = 0; m_cnt = 0; m_addr = 0; m_port = 0;
        end else begin
            m_cnt = m_cnt + int'(m_ea) + int'(m_eb);
            if (m_cnt > CMAX) m_cnt = CMAX;
            if (!m_sticky && (m_ea || m_eb)) begin
                m_sticky = 1;
                m_port   = !m_ea;
                m_addr   = m_ea ? int'(ADRA) : int'(ADRB);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLKA);
        #1;
        check_all();
    endtask

    task automatic idle();
        MEA = 0; WEA = 0; MEB = 0; WEB = 0; inj_par_a = 0; err_clr = 0;
    endtask

    task automatic wr_a(input int a, input logic [DW-1:0] d, input bit inj);
        idle(); MEA = 1; WEA = 1; ADRA = AW'(a); DA = d; inj_par_a = inj;
        tick();
    endtask

    task automatic rd_ab(input bit ea, input int a, input bit eb, input int b);
        idle(); MEA = ea; ADRA = AW'(a); MEB = eb; ADRB = AW'(b);
        tick();
    endtask

    initial begin
        reset_n = 0; scan_mode = 0; ADRA = '0; ADRB = '0; DA = '0; DB = '0;
        idle();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_data[i] = '0; m_bad[i] = 0;
        end
        model_reset();
        #2;
        check_all();
        tick(); tick();
        reset_n = 1;
        tick();

        // Fill every word with clean data so later reads have known contents
        for (int i = 0; i < int'(DEPTH); i += 2) begin
            idle();
            MEA = 1; WEA = 1; ADRA = AW'(i);   DA = DW'({$urandom(), $urandom()});
            MEB = 1; WEB = 1; ADRB = AW'(i+1); DB = DW'({$urandom(), $urandom()});
            tick();
        end

        // Basic write A then read B
        wr_a(5, 36'h123456789, 0);
        rd_ab(0, 0, 1, 5);
        chk("req19_qb", 64'(QB), 64'h123456789);
        chk("req19_errb", 64'(err_b), 64'd0);

        // Injected parity error on A
        wr_a(9, 36'h0F0F0F0F0, 1);
        rd_ab(1, 9, 0, 0);
        chk("req20_erra", 64'(err_a), 64'd1);
        chk("req20_cnt", 64'(err_cnt), 64'd1);
        chk("req20_addr", 64'(err_addr), 64'd9);
        rd_ab(0, 0, 0, 0);
        chk("req20_pulse_end", 64'(err_a), 64'd0);

        // Write-write collision, A wins
        idle(); MEA = 1; WEA = 1; ADRA = 3; DA = 1; MEB = 1; WEB = 1; ADRB = 3; DB = 2;
        tick();
        chk("req21_coll", 64'(coll), 64'd1);
        rd_ab(1, 3, 0, 0);
        chk("req21_coll_end", 64'(coll), 64'd0);
        chk("req21_qa", 64'(QA), 64'd1);

        // Two simultaneous errors after a clear
        wr_a(4, 36'hABCDE, 1);
        wr_a(7, 36'h13579, 1);
        idle(); err_clr = 1; tick();
        rd_ab(1, 4, 1, 7);
        chk("req22_cnt", 64'(err_cnt), 64'd2);
        chk("req22_addr", 64'(err_addr), 64'd4);
        chk("req22_port", 64'(err_port), 64'd0);

        // Read-first on opposite ports, then out-of-range reads and write
        idle(); MEA = 1; WEA = 1; ADRA = 10; DA = 36'h5A5A5A5A5; MEB = 1; ADRB = 10;
        tick();
        rd_ab(1, 50, 1, 63);
        chk("oor_qa", 64'(QA), 64'd0);
        wr_a(50, 36'hFFFFFFFFF, 1);
        rd_ab(1, 10, 1, 50);

        // Clear coincident with an error: pulse still seen, status stays clear
        idle(); MEA = 1; ADRA = 9; err_clr = 1; tick();
        chk("clr_prio_erra", 64'(err_a), 64'd1);
        chk("clr_prio_cnt", 64'(err_cnt), 64'd0);

        // Scan mode blocks accesses and zeroes outputs immediately
        wr_a(2, 36'h222222222, 0);
        rd_ab(1, 2, 1, 9);
        scan_mode = 1;
        #1;
        check_all();
        chk("scan_qa_comb", 64'(QA), 64'd0);
        wr_a(2, 36'h999999999, 1);
        rd_ab(1, 2, 0, 0);
        scan_mode = 0;
        rd_ab(1, 2, 0, 0);
        chk("req23_old", 64'(QA), 64'h222222222);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            MEA = 1'($urandom_range(0, 1)); WEA = 1'($urandom_range(0, 1));
            MEB = 1'($urandom_range(0, 1)); WEB = 1'($urandom_range(0, 1));
            ADRA = AW'($urandom_range(0, 55)); ADRB = AW'($urandom_range(0, 55));
            if ($urandom_range(0, 3) == 0) ADRB = ADRA;
            DA = DW'({$urandom(), $urandom()}); DB = DW'({$urandom(), $urandom()});
            inj_par_a = ($urandom_range(0, 3) == 0);
            err_clr   = ($urandom_range(0, 29) == 0);
            scan_mode = ($urandom_range(0, 19) == 0);
            tick();
        end
        scan_mode = 0;

        // Saturation of the error counter
        wr_a(4, 36'h444, 1);
        wr_a(7, 36'h777, 1);
        for (int n = 0; n < 130; n++) rd_ab(1, 4, 1, 7);
        chk("sat_cnt", 64'(err_cnt), 64'(CMAX));
        rd_ab(1, 4, 0, 0);
        chk("sat_hold", 64'(err_cnt), 64'(CMAX));

        // Reset mid-operation clears valid and status; data survives
        wr_a(9, 36'h0DEADBEEF, 1);
        idle(); MEA = 1; ADRA = 9; MEB = 1; WEB = 1; ADRB = 11; DB = 36'h111;
        reset_n = 0;
        model_reset();
        #1;
        check_all();
        idle();
        tick(); tick();
        reset_n = 1;
        rd_ab(1, 9, 0, 0);
        chk("req24_erra", 64'(err_a), 64'd0);
        chk("req24_cnt", 64'(err_cnt), 64'd0);
        chk("req24_data", 64'(QA), 64'h0DEADBEEF);
        rd_ab(0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sram_dp_par_wrap.md
SRAM_DP_PAR_WRAP -- requirements
Module: sram_dp_par_wrap

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DW, 36, data width per word
- DEPTH, 64, number of words (2 <= DEPTH <= 2**AW)
- AW, 6, address width
- CW, 8, error counter width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- CLKA  in  1  clock for both ports
- reset_n  in  1  reset
- scan_mode  in  1  test mode; blocks accesses and zeroes outputs
- MEA, WEA  in  1  port A enable, write enable
- ADRA  in  AW  port A address
- DA  in  DW  port A write data
- QA  out  DW  port A read data
- MEB, WEB, ADRB, DB, QB  as port A, for port B
- inj_par_a  in  1  invert stored parity on port A writes
- err_clr  in  1  synchronous clear of error status
- err_a, err_b  out  1  parity-error pulse per port
- coll  out  1  write-write collision pulse
- err_sticky  out  1  any error since clear
- err_cnt  out  CW  saturating error count
- err_addr  out  AW  address of first error since clear
- err_port  out  1  port of first error (0=A, 1=B)
REQ-003 Reset SHALL be reset_n, asynchronous, active-low; the clock SHALL be CLKA.

Function
REQ-004 Storage SHALL be DEPTH words of DW+1 bits (data plus even parity) and a DEPTH-bit valid vector; the data array SHALL NOT be reset.
REQ-005 Port x SHALL be enabled when MEx=1, scan_mode=0 and ADRx<DEPTH; otherwise the access SHALL be ignored.
REQ-006 An enabled write (WEx=1) SHALL store Dx with parity = XOR(Dx) at the clock edge, inverted if x=A and inj_par_a=1, and SHALL set valid[ADRx].
REQ-007 An enabled read (WEx=0) SHALL update Qx one cycle later with the stored data; Qx SHALL hold its value between reads.
REQ-008 A read of an out-of-range address SHALL return 0 on Qx one cycle later and SHALL NOT flag an error.
REQ-009 A read of a word with valid=0 SHALL return the stored data and SHALL NOT flag an error.
REQ-010 When both ports write the same address in the same cycle, port A SHALL win, port B's write SHALL be dropped, and coll SHALL pulse high for exactly the next cycle.
REQ-011 A read and a write to the same address on opposite ports in the same cycle SHALL return the old data (read-first).
REQ-012 err_x SHALL pulse for one cycle, coincident with the Qx update, when the read word is valid and XOR(data) differs from the stored parity.
REQ-013 err_cnt SHALL add the number of err pulses in that cycle (0, 1 or 2) and SHALL saturate at 2**CW-1.
REQ-014 On the first error after clear, err_sticky SHALL be set and err_addr and err_port SHALL be captured; if both ports error simultaneously, port A SHALL be recorded.
REQ-015 err_clr=1 SHALL zero err_sticky, err_cnt, err_addr and err_port, with priority over any error in the same cycle; err_a and err_b SHALL still pulse.
REQ-016 With scan_mode=1, QA and QB SHALL be forced to 0 combinationally, and err_a, err_b and coll SHALL be 0.

Reset
REQ-017 While reset_n=0, all outputs and the valid vector SHALL be 0, and the internal Q registers SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL abort any access in flight; after release, all words SHALL read as not valid (no errors flagged).

Verification
REQ-019 Write A addr 5 = 36'h123456789, then read B addr 5 -> QB=36'h123456789 one cycle after the read, err_b=0.
REQ-020 inj_par_a=1 on write to addr 9, then read A addr 9 -> err_a pulses once, err_cnt=1, err_addr=9, err_port=0, err_sticky=1.
REQ-021 Both ports write addr 3 (DA=1, DB=2) in the same cycle -> coll pulses once; a later read of addr 3 returns 1.
REQ-022 Both ports read corrupted words at addrs 4 and 7 in the same cycle -> err_cnt +2, err_addr=4, err_port=0; with err_cnt at 255 (CW=8), a further error -> err_cnt stays 255.
REQ-023 scan_mode=1 during a write to addr 2 then a read -> QA=0, no error; after scan_mode=0, a read of addr 2 shows the old contents.
REQ-024 Reset pulse after writes, then read addr 9 (corrupted) -> no err_a, err_cnt=0.
